// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;
    localparam int SERIAL_SUB_WIDTH = 8;

    // Encoding 2'd3 is unused; the FSM treats it exactly like IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full-subtractor cell: diff = a - b - c, bo = borrow out.
module fs (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic bo
);
    assign diff = a ^ b ^ c;
    assign bo   = (~a & (b | c)) | (b & c);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, LSB first, one bit per clock,
// with valid/ready handshakes on operands and result.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, d_reg;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             load, shift;
    logic             fs_diff, fs_bo;

    fs u_fs (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .c    (brw),
        .diff (fs_diff),
        .bo   (fs_bo)
    );

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        shift       = 1'b0;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        case (state)
            SHIFT: begin
                shift = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            d_reg <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_reg <= a_in;
                b_reg <= b_in;
                d_reg <= '0;
                brw   <= bin;
                cnt   <= '0;
            end else if (shift) begin
                // Difference bits enter at the MSB so bit 0 lands at D[0] after WIDTH shifts.
                d_reg <= {fs_diff, d_reg[WIDTH-1:1]};
                a_reg <= a_reg >> 1;
                b_reg <= b_reg >> 1;
                brw   <= fs_bo;
                cnt   <= cnt + 1'b1;
            end
        end
    end

    assign diff_out = d_reg;
    assign bout     = brw;
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor built around the team's one-bit full-subtractor cell `fs`. It accepts two operands and a borrow-in through a valid/ready handshake. It computes `a - b - bin` LSB-first, one bit per clock, and presents the difference and final borrow-out through a second valid/ready handshake. It sits directly downstream of operand sources that cannot afford a WIDTH-wide ripple subtractor, and trades latency for area.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range ≥ 2.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start_valid` input 1: an operand set is offered.
- `start_ready` output 1: the block can accept an operand set; high only in IDLE.
- `a_in` input WIDTH: minuend.
- `b_in` input WIDTH: subtrahend.
- `bin` input 1: borrow-in for bit 0.
- `res_valid` output 1: result is available; high only in DONE.
- `res_ready` input 1: the consumer takes the result.
- `diff_out` output WIDTH: `(a_in - b_in - bin) mod 2^WIDTH`.
- `bout` output 1: final borrow-out; 1 iff `a_in < b_in + bin` (unsigned).

## Operation
- Registers:
  - `A`, `B`, `D`: WIDTH-bit shift registers.
  - `brw`: 1-bit borrow flop.
  - `cnt`: `$clog2(WIDTH)` bits.
  - `state`.
- State machine:
  - **IDLE**: `start_ready`=1. When `start_valid`=1, load `A`←`a_in`, `B`←`b_in`, `brw`←`bin`, `D`←0, `cnt`←0, then go to SHIFT. Otherwise hold.
  - **SHIFT**: the `fs` cell sees `a`=`A[0]`, `b`=`B[0]`, `c`=`brw`. On each edge:
    - `D`←{`diff`, `D[WIDTH-1:1]`}.
    - `A`←`A>>1`, `B`←`B>>1`.
    - `brw`←`bo`.
    - `cnt`←`cnt+1`.
    - When `cnt`==WIDTH-1 on this edge, go to DONE.
    - `start_valid` is ignored; `start_ready`=0.
  - **DONE**: `res_valid`=1. `diff_out`=`D` and `bout`=`brw`, stable. When `res_ready`=1, go to IDLE. Otherwise hold all registers.
- `diff_out` and `bout` are driven directly from `D` and `brw`. They are valid only while `res_valid`=1, and hold their values in IDLE until the next load.
- Arithmetic is unsigned modulo 2^WIDTH. No overflow flag; signed interpretation is left to the consumer.
- `cnt` never exceeds WIDTH-1, so no wrap-around is visible.

## Timing
- Reset: any edge with `rst_n`=0 forces `state`=IDLE and clears `A`, `B`, `D`, `brw`, `cnt`. After that edge the outputs are:
  - `start_ready`=1
  - `res_valid`=0
  - `diff_out`=0
  - `bout`=0
- Reset mid-operation (in SHIFT or DONE) discards the operation with no result. Reset has priority over every handshake.
- Accept handshake: an operand set is accepted on the edge where `start_valid`&&`start_ready`.
- Latency: `res_valid` rises exactly WIDTH cycles after the accept edge.
- Result handshake: the result is consumed on the edge where `res_valid`&&`res_ready`. `start_ready` is 1 in the next cycle.
- The result cannot be consumed and a new operand set accepted on the same edge. Minimum accept-to-accept interval is WIDTH+2 cycles.
- Holding `res_ready`=0 stalls indefinitely. Outputs must not change while stalled.
- `start_ready` and `res_valid` are decoded combinationally from `state` only. There is no combinational path from any input to any output.

## Structure
- Package `serial_sub_pkg` holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2, 2'd3 decodes as IDLE);
  - the default width constant `SERIAL_SUB_WIDTH`=8.
- Exactly one sub-module: the existing `fs` cell (ports `a`, `b`, `c`, `diff`, `bo`), instantiated once. The top level contains only the FSM, the shift registers and the counter.

## Test plan
- **Basic subtraction** (WIDTH=8): accept `a_in`=8'h5A, `b_in`=8'h3C, `bin`=0 → after 8 cycles `res_valid`=1, `diff_out`=8'h1E, `bout`=0.
- **Underflow and borrow-in chains** (WIDTH=8):
  - 8'h00 - 8'h01 with `bin`=0 → 8'hFF, `bout`=1.
  - 8'hFF - 8'hFF with `bin`=1 → 8'hFF, `bout`=1.
  - 8'h10 - 8'h0F with `bin`=1 → 8'h00, `bout`=0.
- **Backpressure**:
  - Hold `res_ready`=0 for 5 cycles in DONE → outputs stable, `start_ready`=0.
  - Pulse `start_valid` with different operands during SHIFT → ignored; the result matches the first operand set.
- **Reset mid-operation**: drop `rst_n` for 1 cycle at shift 3 → next cycle IDLE, all outputs at reset values. A fresh operation then completes correctly.
- **Exhaustive check** (WIDTH=4): all 512 combinations of (`a`, `b`, `bin`), back-to-back with `res_ready`=1. Each result must equal (`a`-`b`-`bin`) mod 16 with the correct `bout`. The accept-to-accept interval must be exactly 6 cycles.
